// File: rtl/fp_pkg.sv
// Shared constants, FSM state codes and 8-bit code layout for the float encode/decode path.
package fp_pkg;

    localparam int unsigned EXP_W  = 3;
    localparam int unsigned MANT_W = 4;
    localparam int unsigned OUT_W  = 12;
    localparam int unsigned CODE_W = 1 + EXP_W + MANT_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    typedef struct packed {
        logic              s;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] f;
    } fp_code_t;

    function automatic fp_code_t unpack_code(input logic [CODE_W-1:0] raw);
        return fp_code_t'(raw);
    endfunction

endpackage

// File: rtl/fp_decode_if.sv
// Input code and output result handshakes of fp_decode; the slave modport is the decoder side.
interface fp_decode_if #(
    parameter int unsigned EXP_W  = fp_pkg::EXP_W,
    parameter int unsigned MANT_W = fp_pkg::MANT_W,
    parameter int unsigned OUT_W  = fp_pkg::OUT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic              S;
    logic [EXP_W-1:0]  E;
    logic [MANT_W-1:0] F;
    logic [OUT_W-1:0]  D;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_valid, S, E, F, out_ready,
        input  in_ready, D, out_valid
    );

    modport slave (
        input  in_valid, S, E, F, out_ready,
        output in_ready, D, out_valid
    );

endinterface

// File: rtl/fpdec_shift_unit.sv
// Magnitude datapath: serial shift by E (default) or one-step barrel shift when FPDEC_BARREL_EN is defined.
module fpdec_shift_unit #(
    parameter int unsigned EXP_W  = fp_pkg::EXP_W,
    parameter int unsigned MANT_W = fp_pkg::MANT_W,
    parameter int unsigned OUT_W  = fp_pkg::OUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [EXP_W-1:0]  e_i,
    input  logic [MANT_W-1:0] f_i,
    output logic [OUT_W-2:0]  mag_o,
    output logic              done_o
);

    localparam int unsigned MAG_W = OUT_W - 1;

    logic [MAG_W-1:0] f_ext;
    logic [MAG_W-1:0] mag_q, mag_d;

    assign f_ext = {{(MAG_W-MANT_W){1'b0}}, f_i};
    assign mag_o = mag_q;

`ifdef FPDEC_BARREL_EN
    // The whole shift happens on the load edge, so the magnitude is ready in the next state.
    logic unused_step;
    logic unused_e;
    assign unused_step = step_i;
    assign unused_e    = 1'b0;
    assign done_o      = 1'b1;

    always_comb begin
        mag_d = mag_q;
        if (load_i) begin
            mag_d = f_ext << e_i;
        end
    end
`else
    logic [EXP_W-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == '0);

    always_comb begin
        mag_d = mag_q;
        cnt_d = cnt_q;
        if (load_i) begin
            mag_d = f_ext;
            cnt_d = e_i;
        end else if (step_i && (cnt_q != '0)) begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

endmodule

// File: rtl/fp_decode.sv
// Expands an {S,E,F} float code into a two's-complement linear value behind valid/ready handshakes.
// Define FPDEC_BARREL_EN for fixed one-cycle latency via a barrel shifter instead of serial shifting.
module fp_decode
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = fp_pkg::EXP_W,
    parameter int unsigned MANT_W = fp_pkg::MANT_W,
    parameter int unsigned OUT_W  = fp_pkg::OUT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_decode_if.slave  bus
);

    logic [1:0]       state_q, state_d;
    logic             sgn_q, sgn_d;
    logic [OUT_W-1:0] d_q, d_d;
    logic             out_valid_q, out_valid_d;

    logic             load;
    logic             step;
    logic             done;
    logic [OUT_W-2:0] mag;
    logic [OUT_W-1:0] mag_ext;

    fpdec_shift_unit #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .OUT_W  (OUT_W)
    ) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .e_i    (bus.E),
        .f_i    (bus.F),
        .mag_o  (mag),
        .done_o (done)
    );

    assign mag_ext       = {1'b0, mag};
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;

    always_comb begin
        state_d     = state_q;
        sgn_d       = sgn_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    sgn_d   = bus.S;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (done) begin
                    // Negating a zero magnitude yields zero, so S=1,F=0 never produces a negative zero.
                    d_d         = sgn_q ? ('0 - mag_ext) : mag_ext;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sgn_q       <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sgn_q       <= sgn_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp_decode.sv
// Self-checking bench for fp_decode: directed vectors, backpressure, mid-operation reset and random codes.
module tb_fp_decode;
    import fp_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    fp_decode_if #(.EXP_W(3), .MANT_W(4), .OUT_W(12)) bus ();

    fp_decode #(.EXP_W(3), .MANT_W(4), .OUT_W(12)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: value = (-1)^S * F * 2^E, truncated to 12 bits.
    function automatic logic [11:0] ref_d(input int s, input int e, input int f);
        int v;
        v = f * (1 << e);
        if (s != 0) v = -v;
        return v[11:0];
    endfunction

    function automatic int ref_lat(input int e);
`ifdef FPDEC_BARREL_EN
        return 1 + 0 * e;
`else
        return e + 1;
`endif
    endfunction

    // Presents one code for a single edge; call with the bench at posedge+1.
    task automatic send_code(input int s, input int e, input int f);
        bus.S        = s[0];
        bus.E        = e[2:0];
        bus.F        = f[3:0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen; -1 if it never appears within the budget.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.out_valid) cyc = -1;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.D !== 12'h000) $display("FAIL reset_D got=%h exp=000", bus.D);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        int vs [5] = '{0, 0, 1, 1, 1};
        int ve [5] = '{0, 7, 2, 7, 4};
        int vf [5] = '{0, 15, 9, 15, 0};
        int cyc;
        logic [11:0] exp_d;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_d = ref_d(vs[i], ve[i], vf[i]);
            send_code(vs[i], ve[i], vf[i]);
            total_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL dir_accept[%0d] in_ready got=%b exp=0", i, bus.in_ready);
            else pass_cnt++;
            wait_valid(cyc);
            total_cnt++;
            if (cyc !== ref_lat(ve[i])) $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, cyc, ref_lat(ve[i]));
            else pass_cnt++;
            total_cnt++;
            if (bus.D !== exp_d) $display("FAIL dir_D[%0d] got=%h exp=%h", i, bus.D, exp_d);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
                $display("FAIL dir_return[%0d] got ov=%b ir=%b exp ov=0 ir=1", i, bus.out_valid, bus.in_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        logic [11:0] exp_d;
        exp_d = ref_d(0, 1, 5);
        bus.out_ready = 1'b0;
        send_code(0, 1, 5);
        wait_valid(cyc);
        total_cnt++;
        if (cyc !== ref_lat(1)) $display("FAIL bp_latency got=%0d exp=%0d", cyc, ref_lat(1));
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus.S = 1'b0; bus.E = 3'd3; bus.F = 4'd7;
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            total_cnt++;
            if (bus.D !== exp_d || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] got D=%h ov=%b ir=%b exp D=%h ov=1 ir=0",
                         i, bus.D, bus.out_valid, bus.in_ready, exp_d);
            else pass_cnt++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.D !== exp_d)
                $display("FAIL bp_no_extra[%0d] got ov=%b D=%h exp ov=0 D=%h", i, bus.out_valid, bus.D, exp_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bus.out_ready = 1'b1;
        send_code(0, 5, 3);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.D !== 12'h000 || bus.in_ready !== 1'b1)
            $display("FAIL rst_shift got ov=%b D=%h ir=%b exp ov=0 D=000 ir=1", bus.out_valid, bus.D, bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_code(0, 1, 1);
        wait_valid(cyc);
        total_cnt++;
        if (cyc !== ref_lat(1) || bus.D !== ref_d(0, 1, 1))
            $display("FAIL rst_after got cyc=%0d D=%h exp cyc=%0d D=%h", cyc, bus.D, ref_lat(1), ref_d(0, 1, 1));
        else pass_cnt++;
        @(posedge clk);
        #1;
        // Abort while a result is being held for the consumer.
        bus.out_ready = 1'b0;
        send_code(0, 0, 9);
        wait_valid(cyc);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.D !== 12'h000 || bus.in_ready !== 1'b1)
            $display("FAIL rst_out got ov=%b D=%h ir=%b exp ov=0 D=000 ir=1", bus.out_valid, bus.D, bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int cyc;
        bus.out_ready = 1'b1;
        send_code(0, 2, 3);
        wait_valid(cyc);
        bus.S = 1'b1; bus.E = 3'd1; bus.F = 4'd2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL b2b_consume_edge got ir=%b ov=%b exp ir=1 ov=0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL b2b_accept got ir=%b exp=0", bus.in_ready);
        else pass_cnt++;
        wait_valid(cyc);
        total_cnt++;
        if (cyc !== ref_lat(1) || bus.D !== ref_d(1, 1, 2))
            $display("FAIL b2b_result got cyc=%0d D=%h exp cyc=%0d D=%h", cyc, bus.D, ref_lat(1), ref_d(1, 1, 2));
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        fp_code_t    c;
        int          hold;
        int          cyc;
        logic [11:0] exp_d;
        for (int i = 0; i < 40; i++) begin
            c     = unpack_code(8'($urandom_range(0, 255)));
            hold  = $urandom_range(0, 3);
            exp_d = ref_d(int'(c.s), int'(c.e), int'(c.f));
            bus.out_ready = (hold == 0);
            send_code(int'(c.s), int'(c.e), int'(c.f));
            wait_valid(cyc);
            total_cnt++;
            if (cyc !== ref_lat(int'(c.e)) || bus.D !== exp_d)
                $display("FAIL rnd[%0d] S=%0d E=%0d F=%0d got cyc=%0d D=%h exp cyc=%0d D=%h",
                         i, c.s, c.e, c.f, cyc, bus.D, ref_lat(int'(c.e)), exp_d);
            else pass_cnt++;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                total_cnt++;
                if (bus.out_valid !== 1'b1 || bus.D !== exp_d)
                    $display("FAIL rnd_hold[%0d] got ov=%b D=%h exp ov=1 D=%h", i, bus.out_valid, bus.D, exp_d);
                else pass_cnt++;
            end
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.D !== exp_d)
                $display("FAIL rnd_done[%0d] got ov=%b ir=%b D=%h exp ov=0 ir=1 D=%h",
                         i, bus.out_valid, bus.in_ready, bus.D, exp_d);
            else pass_cnt++;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.S         = 1'b0;
        bus.E         = '0;
        bus.F         = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
